// File: rtl/led_sequencer_pkg.sv
// Shared definitions for the LED sequencer: FSM state encoding and the
// default latch-gap length (50 us of WS281x reset low time at 12 MHz).
package led_sequencer_pkg;

  typedef enum logic [1:0] {
    LED_SEQ_IDLE  = 2'd0,
    LED_SEQ_SHIFT = 2'd1,
    LED_SEQ_LATCH = 2'd2
  } led_seq_state_e;

  localparam int unsigned LED_SEQ_LATCH_CYCLES = 600;

endpackage

// File: rtl/led_sequencer_latch_timer.sv
// led_latch_timer: loadable down-counter for the strip latch gap.
// After load with N-1 it stays active for exactly N cycles; expire_o is
// high during the last of them. abort_i cancels a running count.
module led_latch_timer #(
  parameter int unsigned LAT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             abort_i,
  input  logic [LAT_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [LAT_W-1:0] count_q, count_d;
  logic             active_q, active_d;

  // Next-state: abort beats load, load beats counting.
  always_comb begin
    count_d  = count_q;
    active_d = active_q;
    if (abort_i) begin
      active_d = 1'b0;
    end else if (load_i) begin
      count_d  = load_val_i;
      active_d = 1'b1;
    end else if (active_q) begin
      if (count_q == '0) begin
        active_d = 1'b0;
      end else begin
        count_d = count_q - LAT_W'(1);
      end
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q  <= '0;
      active_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
    end
  end

  assign expire_o = active_q && (count_q == '0);

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: walks an LED index across a run-time-selectable strip
// length in either direction, one step per accepted LED word, then holds
// a latch gap before pulsing done.
// Optional build macro LED_SEQ_REPEAT_EN adds input led_repeat: when high
// at latch expiry the next frame starts directly without an IDLE cycle.
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int unsigned NUM_LEDS     = 150,
  parameter int unsigned IDX_W        = 8,
  parameter int unsigned LATCH_CYCLES = LED_SEQ_LATCH_CYCLES,
  parameter int unsigned LAT_W        = 16
) (
  input  logic             led_clock,
  input  logic             led_reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic [IDX_W-1:0] led_length,
  input  logic             dir_up,
  input  logic             led_ack,
`ifdef LED_SEQ_REPEAT_EN
  // Named led_repeat because 'repeat' is a reserved word.
  input  logic             led_repeat,
`endif
  output logic [IDX_W-1:0] led_index,
  output logic             led_valid,
  output logic             busy,
  output logic             latching,
  output logic             done
);

  localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W+1)'(NUM_LEDS);
  localparam logic [IDX_W-1:0] LAST_MAX = IDX_W'(NUM_LEDS - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATCH_CYCLES - 1);

  led_seq_state_e   state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             dir_q, dir_d;

  logic             len_oor;
  logic [IDX_W-1:0] start_last;
  logic [IDX_W-1:0] start_idx;
  logic             at_last;
  logic             timer_load;
  logic             timer_abort;
  logic             latch_expire;

  // Frame parameters derived from the live inputs, used whenever a frame begins.
  always_comb begin
    len_oor    = (led_length == '0) || ({1'b0, led_length} > NUM_EXT);
    start_last = len_oor ? LAST_MAX : (led_length - IDX_W'(1));
    start_idx  = dir_up ? '0 : start_last;
    at_last    = dir_q ? (idx_q == last_q) : (idx_q == '0);
  end

  // FSM next-state, index stepping and done pulse.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    dir_d       = dir_q;
    timer_load  = 1'b0;
    timer_abort = 1'b0;
    done        = 1'b0;
    case (state_q)
      LED_SEQ_IDLE: begin
        if (start && !stop) begin
          last_d  = start_last;
          dir_d   = dir_up;
          idx_d   = start_idx;
          state_d = LED_SEQ_SHIFT;
        end
      end
      LED_SEQ_SHIFT: begin
        if (stop) begin
          state_d = LED_SEQ_IDLE;
        end else if (led_ack) begin
          if (at_last) begin
            state_d    = LED_SEQ_LATCH;
            timer_load = 1'b1;
          end else begin
            idx_d = dir_q ? (idx_q + IDX_W'(1)) : (idx_q - IDX_W'(1));
          end
        end
      end
      LED_SEQ_LATCH: begin
        if (stop) begin
          state_d     = LED_SEQ_IDLE;
          timer_abort = 1'b1;
        end else if (latch_expire) begin
          done = 1'b1;
`ifdef LED_SEQ_REPEAT_EN
          if (led_repeat) begin
            last_d  = start_last;
            dir_d   = dir_up;
            idx_d   = start_idx;
            state_d = LED_SEQ_SHIFT;
          end else begin
            state_d = LED_SEQ_IDLE;
          end
`else
          state_d = LED_SEQ_IDLE;
`endif
        end
      end
      default: state_d = LED_SEQ_IDLE;
    endcase
  end

  // State, index and captured frame parameters.
  always_ff @(posedge led_clock) begin
    if (!led_reset_n) begin
      state_q <= LED_SEQ_IDLE;
      idx_q   <= LAST_MAX;
      last_q  <= LAST_MAX;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      dir_q   <= dir_d;
    end
  end

  led_latch_timer #(
    .LAT_W(LAT_W)
  ) u_latch_timer (
    .clk_i      (led_clock),
    .rst_ni     (led_reset_n),
    .load_i     (timer_load),
    .abort_i    (timer_abort),
    .load_val_i (LAT_LOAD),
    .expire_o   (latch_expire)
  );

  assign led_index = idx_q;
  assign led_valid = (state_q == LED_SEQ_SHIFT);
  assign busy      = (state_q == LED_SEQ_SHIFT) || (state_q == LED_SEQ_LATCH);
  assign latching  = (state_q == LED_SEQ_LATCH);

endmodule

// File: tb/tb_led_sequencer.sv
// Directed testbench for led_sequencer with default parameters
// (150 LEDs, 8-bit index, 600-cycle latch gap).
module tb_led_sequencer;

  logic       led_clock;
  logic       led_reset_n;
  logic       start;
  logic       stop;
  logic [7:0] led_length;
  logic       dir_up;
  logic       led_ack;
`ifdef LED_SEQ_REPEAT_EN
  logic       rep;
`endif
  logic [7:0] led_index;
  logic       led_valid;
  logic       busy;
  logic       latching;
  logic       done;

  int errors = 0;
  int checks = 0;

  led_sequencer #(
    .NUM_LEDS     (150),
    .IDX_W        (8),
    .LATCH_CYCLES (600),
    .LAT_W        (16)
  ) dut (
    .led_clock   (led_clock),
    .led_reset_n (led_reset_n),
    .start       (start),
    .stop        (stop),
    .led_length  (led_length),
    .dir_up      (dir_up),
    .led_ack     (led_ack),
`ifdef LED_SEQ_REPEAT_EN
    .led_repeat  (rep),
`endif
    .led_index   (led_index),
    .led_valid   (led_valid),
    .busy        (busy),
    .latching    (latching),
    .done        (done)
  );

  initial led_clock = 1'b0;
  always #5 led_clock = ~led_clock;

  task automatic tick();
    @(posedge led_clock);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    led_reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if (led_index !== 8'd149 || led_valid !== 1'b0 || busy !== 1'b0 ||
        latching !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: idx=%0d v=%b b=%b l=%b d=%b, required 149 0 0 0 0",
               led_index, led_valid, busy, latching, done);
    end
    led_reset_n = 1'b1;
    tick();
    // Reset in the middle of a frame.
    led_length = 8'd0; dir_up = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; led_ack = 1'b1;
    for (int i = 0; i < 37; i++) tick();
    led_ack = 1'b0;
    checks++;
    if (led_index !== 8'd37 || led_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_idx: idx=%0d v=%b, required 37 1", led_index, led_valid);
    end
    led_reset_n = 1'b0;
    tick();
    checks++;
    if (led_index !== 8'd149 || led_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_frame: idx=%0d v=%b b=%b d=%b, required 149 0 0 0",
               led_index, led_valid, busy, done);
    end
    led_reset_n = 1'b1;
    tick();
  endtask

  task automatic test_full_down();
    int lat = 0;
    int dn  = 0;
    int done_at = 0;
    led_length = 8'd0; dir_up = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; led_ack = 1'b1;
    for (int i = 0; i < 150; i++) begin
      checks++;
      if (led_index !== 8'(149 - i) || led_valid !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL down_seq[%0d]: idx=%0d v=%b b=%b, required %0d 1 1",
                 i, led_index, led_valid, busy, 149 - i);
      end
      tick();
    end
    led_ack = 1'b0;
    checks++;
    if (latching !== 1'b1 || led_valid !== 1'b0 || led_index !== 8'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL down_latch_entry: l=%b v=%b idx=%0d b=%b, required 1 0 0 1",
               latching, led_valid, led_index, busy);
    end
    for (int n = 0; n < 2000; n++) begin
      if (latching !== 1'b1) break;
      lat++;
      if (done === 1'b1) begin
        dn++;
        done_at = lat;
      end
      tick();
    end
    checks++;
    if (lat != 600) begin
      errors++;
      $display("FAIL down_latch_len: got %0d cycles, required 600", lat);
    end
    checks++;
    if (dn != 1 || done_at != 600) begin
      errors++;
      $display("FAIL down_done: pulses=%0d at cycle %0d, required 1 at 600", dn, done_at);
    end
    checks++;
    if (busy !== 1'b0 || led_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL down_idle: b=%b v=%b d=%b, required 0 0 0", busy, led_valid, done);
    end
  endtask

  task automatic test_slow_up();
    led_length = 8'd4; dir_up = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (led_index !== 8'(k) || led_valid !== 1'b1) begin
          errors++;
          $display("FAIL slow_up[%0d.%0d]: idx=%0d v=%b, required %0d 1",
                   k, c, led_index, led_valid, k);
        end
        led_ack = (c == 2);
        tick();
      end
    end
    led_ack = 1'b0;
    checks++;
    if (led_valid !== 1'b0 || latching !== 1'b1 || led_index !== 8'd3) begin
      errors++;
      $display("FAIL slow_up_end: v=%b l=%b idx=%0d, required 0 1 3",
               led_valid, latching, led_index);
    end
    wait_idle("slow_up");
  endtask

  task automatic test_len_edges();
    led_length = 8'd1; dir_up = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (led_index !== 8'd0 || led_valid !== 1'b1) begin
      errors++;
      $display("FAIL len1_first: idx=%0d v=%b, required 0 1", led_index, led_valid);
    end
    led_ack = 1'b1;
    tick();
    led_ack = 1'b0;
    checks++;
    if (latching !== 1'b1 || led_valid !== 1'b0 || led_index !== 8'd0) begin
      errors++;
      $display("FAIL len1_latch: l=%b v=%b idx=%0d, required 1 0 0",
               latching, led_valid, led_index);
    end
    wait_idle("len1");
    led_length = 8'd200; dir_up = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; led_ack = 1'b1;
    for (int i = 0; i < 150; i++) begin
      checks++;
      if (led_index !== 8'(i) || led_valid !== 1'b1) begin
        errors++;
        $display("FAIL clamp_seq[%0d]: idx=%0d v=%b, required %0d 1",
                 i, led_index, led_valid, i);
      end
      tick();
    end
    led_ack = 1'b0;
    checks++;
    if (latching !== 1'b1 || led_index !== 8'd149) begin
      errors++;
      $display("FAIL clamp_end: l=%b idx=%0d, required 1 149", latching, led_index);
    end
    wait_idle("clamp");
  endtask

  task automatic test_stop();
    int dn = 0;
    led_length = 8'd3; dir_up = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; led_ack = 1'b1;
    tick();
    tick();
    led_ack = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (led_valid !== 1'b0 || busy !== 1'b0 || led_index !== 8'd2) begin
      errors++;
      $display("FAIL stop_shift: v=%b b=%b idx=%0d, required 0 0 2", led_valid, busy, led_index);
    end
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || led_valid !== 1'b0) begin
      errors++;
      $display("FAIL stop_blocks_start: b=%b v=%b, required 0 0", busy, led_valid);
    end
    led_length = 8'd2; start = 1'b1;
    tick();
    start = 1'b0; led_ack = 1'b1;
    tick();
    tick();
    led_ack = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (latching !== 1'b1) begin
      errors++;
      $display("FAIL stop_pre_latch: l=%b, required 1", latching);
    end
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    checks++;
    if (latching !== 1'b0 || busy !== 1'b0 || led_valid !== 1'b0 || led_index !== 8'd1) begin
      errors++;
      $display("FAIL stop_latch: l=%b b=%b v=%b idx=%0d, required 0 0 0 1",
               latching, busy, led_valid, led_index);
    end
    for (int i = 0; i < 700; i++) begin
      if (done === 1'b1 || busy === 1'b1) dn++;
      tick();
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL stop_no_done: activity seen in %0d cycles, required 0", dn);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    led_length = 8'd3; dir_up = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; led_ack = 1'b1;
    led_length = 8'd5; dir_up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (led_index !== 8'(i) || led_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_seq[%0d]: idx=%0d v=%b, required %0d 1", i, led_index, led_valid, i);
      end
      tick();
    end
    while (done !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1 || latching !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: d=%b l=%b, required 1 1", done, latching);
    end
    start = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap: b=%b d=%b, required 0 0", busy, done);
    end
    tick();
    start = 1'b0;
    checks++;
    if (led_valid !== 1'b1 || led_index !== 8'd4) begin
      errors++;
      $display("FAIL b2b_restart: v=%b idx=%0d, required 1 4", led_valid, led_index);
    end
    wait_idle("b2b");
    for (int i = 0; i < 3; i++) tick();
    led_ack = 1'b0;
    checks++;
    if (led_index !== 8'd0 || led_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ack_in_idle: idx=%0d v=%b b=%b, required 0 0 0", led_index, led_valid, busy);
    end
  endtask

`ifdef LED_SEQ_REPEAT_EN
  task automatic test_repeat();
    int dn = 0;
    led_length = 8'd3; dir_up = 1'b1; rep = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; led_ack = 1'b1;
    for (int n = 0; n < 3000 && dn < 2; n++) begin
      if (done === 1'b1) begin
        dn++;
        tick();
        checks++;
        if (led_valid !== 1'b1 || latching !== 1'b0 || led_index !== 8'd0) begin
          errors++;
          $display("FAIL repeat_reenter: v=%b l=%b idx=%0d, required 1 0 0",
                   led_valid, latching, led_index);
        end
      end else begin
        tick();
      end
    end
    rep = 1'b0;
    wait_idle("repeat");
    led_ack = 1'b0;
    checks++;
    if (dn != 2) begin
      errors++;
      $display("FAIL repeat_done_count: got %0d, required 2", dn);
    end
  endtask
`endif

  initial begin
    start = 1'b0; stop = 1'b0; led_length = 8'd0; dir_up = 1'b0;
    led_ack = 1'b0; led_reset_n = 1'b0;
`ifdef LED_SEQ_REPEAT_EN
    rep = 1'b0;
`endif
    #2;
    test_reset();
    test_full_down();
    test_slow_up();
    test_len_edges();
    test_stop();
    test_back_to_back();
`ifdef LED_SEQ_REPEAT_EN
    test_repeat();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
